// File: rtl/mem_access_release_sched_pkg.sv
// Shared constants, FSM state type and the wrap-safe time comparison used by
// the memory-access release scheduler.
package mem_access_release_sched_pkg;

  localparam int FIFO_DEPTH = 32;
  localparam int DEPTH_LOG  = 5;
  localparam int CNT_W      = 16;
  localparam int RAM_LOG    = 5;
  localparam int ADDR_W     = 32;
  localparam int OCC_W      = DEPTH_LOG + 1;

  // Occupancy ceiling: the FIFO reports full one entry short of its depth.
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    REQ   = 2'd2
  } sched_state_t;

  // True when 'now' has reached or passed 't', treating the difference as a
  // signed value so the comparison survives timebase wrap. Only delays below
  // half the timebase range are meaningful.
  function automatic logic time_reached(input logic [CNT_W-1:0] now,
                                        input logic [CNT_W-1:0] t);
    logic [CNT_W-1:0] diff;
    diff = now - t;
    return ~diff[CNT_W-1];
  endfunction

endpackage

// File: rtl/mem_access_release_sched_if.sv
// Signal bundle between the delay FIFO / RAM port side and the release
// scheduler. The slave modport is the scheduler's view.
//
// Handshake: a request transfers on a rising clk edge where req_valid_o and
// req_ready_i are both 1 and stall_i is 0. Once req_valid_o is raised it stays
// high with req_ram_o/req_addr_o unchanged until that transfer happens;
// req_ready_i may change freely and has no effect while req_valid_o is 0.
interface mem_access_release_sched_if;
  import mem_access_release_sched_pkg::*;

  logic                stall_i;
  logic                push_i;
  logic [RAM_LOG-1:0]  head_ram_i;
  logic [CNT_W-1:0]    head_in_i;
  logic [CNT_W-1:0]    head_out_i;
  logic [ADDR_W-1:0]   head_addr_i;
  logic [CNT_W-1:0]    count_o;
  logic                pop_o;
  logic                req_valid_o;
  logic                req_ready_i;
  logic [RAM_LOG-1:0]  req_ram_o;
  logic [ADDR_W-1:0]   req_addr_o;
  logic                lat_valid_o;
  logic [CNT_W-1:0]    lat_o;
  logic [CNT_W-1:0]    lat_max_o;
  logic [OCC_W-1:0]    occ_o;
  sched_state_t        state;

  modport master (
    output stall_i, push_i, head_ram_i, head_in_i, head_out_i, head_addr_i,
           req_ready_i,
    input  count_o, pop_o, req_valid_o, req_ram_o, req_addr_o, lat_valid_o,
           lat_o, lat_max_o, occ_o, state
  );

  modport slave (
    input  stall_i, push_i, head_ram_i, head_in_i, head_out_i, head_addr_i,
           req_ready_i,
    output count_o, pop_o, req_valid_o, req_ram_o, req_addr_o, lat_valid_o,
           lat_o, lat_max_o, occ_o, state
  );

endinterface

// File: rtl/mem_access_timebase.sv
// Free-running timebase stamped into FIFO entries. Advances once per
// unstalled cycle and wraps naturally at 2^CNT_W.
module mem_access_timebase
  import mem_access_release_sched_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] count_next
);

  assign count_next = stall ? count : count + CNT_W'(1);

  // Counter register; stall holds the current value.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/mem_access_release_sched.sv
// Release scheduler for the memory-access delay FIFO. Tracks FIFO occupancy,
// waits until the head entry's release time, issues it to the RAM port with a
// valid/ready handshake, pops the FIFO on acceptance and records the queueing
// latency of every issued access.
module mem_access_release_sched
  import mem_access_release_sched_pkg::*;
(
  input logic                       clk,
  input logic                       reset,
  mem_access_release_sched_if.slave bus
);

  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_next;
  sched_state_t       state;
  logic               req_valid;
  logic [RAM_LOG-1:0] req_ram;
  logic [ADDR_W-1:0]  req_addr;
  logic [CNT_W-1:0]   req_in;
  logic [OCC_W-1:0]   occ;
  logic [OCC_W-1:0]   occ_next;
  logic [CNT_W-1:0]   lat_now;
  logic [CNT_W-1:0]   lat_last;
  logic [CNT_W-1:0]   lat_max;
  logic               push_eff;
  logic               accept;
  logic               due;

  mem_access_timebase u_timebase (
    .clk        (clk),
    .reset      (reset),
    .stall      (bus.stall_i),
    .count      (count),
    .count_next (count_next)
  );

  // A transfer happens only on an unstalled edge outside reset.
  assign accept   = req_valid & bus.req_ready_i & ~bus.stall_i & ~reset;
  // Pushes into a full FIFO are dropped by the FIFO itself, so ignore them here.
  assign push_eff = bus.push_i & ~bus.stall_i & (occ != OCC_FULL);
  // Compare against the timebase value of the next cycle so that req_valid_o
  // rises in the very cycle the timebase reaches the release time.
  assign due      = time_reached(count_next, bus.head_out_i);
  assign lat_now  = count - req_in;

  // Next occupancy: simultaneous push and pop cancel out.
  always_comb begin
    occ_next = occ;
    if (push_eff && !accept) begin
      occ_next = occ + OCC_W'(1);
    end else if (accept && !push_eff) begin
      occ_next = occ - OCC_W'(1);
    end
  end

  // Occupancy register, frozen during stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      occ <= '0;
    end else if (!bus.stall_i) begin
      occ <= occ_next;
    end
  end

  // Release FSM: wait for an entry, wait for it to become due, then hold the
  // request until the RAM port accepts it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      req_valid <= 1'b0;
      req_ram   <= '0;
      req_addr  <= '0;
      req_in    <= '0;
    end else if (!bus.stall_i) begin
      case (state)
        IDLE: begin
          if (occ_next != '0) begin
            state <= CHECK;
          end
        end
        CHECK: begin
          if (due) begin
            state     <= REQ;
            req_valid <= 1'b1;
            req_ram   <= bus.head_ram_i;
            req_addr  <= bus.head_addr_i;
            req_in    <= bus.head_in_i;
          end
        end
        REQ: begin
          if (accept) begin
            req_valid <= 1'b0;
            state     <= (occ_next != '0) ? CHECK : IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          req_valid <= 1'b0;
        end
      endcase
    end
  end

  // Latency statistics, updated on every accepted request.
  always_ff @(posedge clk) begin
    if (reset) begin
      lat_last <= '0;
      lat_max  <= '0;
    end else if (accept) begin
      lat_last <= lat_now;
      if (lat_now > lat_max) begin
        lat_max <= lat_now;
      end
    end
  end

  // Underflow guard: a pop must never be issued while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (!reset && accept) begin
      assert (occ != '0);
    end
  end

  assign bus.count_o     = count;
  assign bus.pop_o       = accept;
  assign bus.req_valid_o = req_valid;
  assign bus.req_ram_o   = req_ram;
  assign bus.req_addr_o  = req_addr;
  assign bus.lat_valid_o = accept;
  assign bus.lat_o       = accept ? lat_now : lat_last;
  assign bus.lat_max_o   = lat_max;
  assign bus.occ_o       = occ;
  assign bus.state       = state;

endmodule

// File: tb/tb_mem_access_release_sched.sv
// Directed bench for the memory-access release scheduler.
module tb_mem_access_release_sched;
  import mem_access_release_sched_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   tests    = 0;
  int   failures = 0;
  int   npops;

  mem_access_release_sched_if bus ();

  mem_access_release_sched dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock
  always #5 clk = ~clk;

  // Move to just after the next rising edge; inputs are driven from here.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Let combinational outputs settle before sampling.
  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic idle_inputs();
    bus.stall_i     = 1'b0;
    bus.push_i      = 1'b0;
    bus.head_ram_i  = '0;
    bus.head_in_i   = '0;
    bus.head_out_i  = '0;
    bus.head_addr_i = '0;
    bus.req_ready_i = 1'b0;
  endtask

  task automatic push_entry(input logic [CNT_W-1:0] tin, input logic [CNT_W-1:0] tout,
                            input logic [RAM_LOG-1:0] ram, input logic [ADDR_W-1:0] addr);
    bus.push_i      = 1'b1;
    bus.head_in_i   = tin;
    bus.head_out_i  = tout;
    bus.head_ram_i  = ram;
    bus.head_addr_i = addr;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    cyc();
    cyc();
    reset = 1'b0;
    settle();

    // Reset state
    chk("rst_count", 32'(bus.count_o), 0);
    chk("rst_occ", 32'(bus.occ_o), 0);
    chk("rst_req_valid", 32'(bus.req_valid_o), 0);
    chk("rst_pop", 32'(bus.pop_o), 0);
    chk("rst_lat_valid", 32'(bus.lat_valid_o), 0);
    chk("rst_lat", 32'(bus.lat_o), 0);
    chk("rst_lat_max", 32'(bus.lat_max_o), 0);
    chk("rst_state", 32'(bus.state), 32'(IDLE));

    // 1. Free-running timebase with nothing queued
    for (int i = 1; i <= 100; i++) begin
      cyc();
      settle();
      chk("t1_count", 32'(bus.count_o), i);
      chk("t1_req_valid", 32'(bus.req_valid_o), 0);
      chk("t1_occ", 32'(bus.occ_o), 0);
    end

    // 2. Push at count 10, release at 15, RAM always ready
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    settle();
    chk("t2_count_after_reset", 32'(bus.count_o), 0);
    for (int i = 0; i < 10; i++) cyc();
    settle();
    chk("t2_count_at_push", 32'(bus.count_o), 10);
    push_entry(16'd10, 16'd15, 5'h0a, 32'hdead_beef);
    bus.req_ready_i = 1'b1;
    cyc();
    bus.push_i = 1'b0;
    settle();
    chk("t2_occ", 32'(bus.occ_o), 1);
    chk("t2_state_check", 32'(bus.state), 32'(CHECK));
    for (int c = 11; c < 15; c++) begin
      chk("t2_wait_count", 32'(bus.count_o), c);
      chk("t2_wait_valid", 32'(bus.req_valid_o), 0);
      chk("t2_wait_pop", 32'(bus.pop_o), 0);
      cyc();
      settle();
    end
    chk("t2_issue_count", 32'(bus.count_o), 15);
    chk("t2_issue_valid", 32'(bus.req_valid_o), 1);
    chk("t2_issue_ram", 32'(bus.req_ram_o), 32'h0a);
    chk("t2_issue_addr", bus.req_addr_o, 32'hdead_beef);
    chk("t2_pop", 32'(bus.pop_o), 1);
    chk("t2_lat_valid", 32'(bus.lat_valid_o), 1);
    chk("t2_lat", 32'(bus.lat_o), 5);
    cyc();
    settle();
    chk("t2_after_valid", 32'(bus.req_valid_o), 0);
    chk("t2_after_pop", 32'(bus.pop_o), 0);
    chk("t2_after_occ", 32'(bus.occ_o), 0);
    chk("t2_after_state", 32'(bus.state), 32'(IDLE));
    chk("t2_lat_max", 32'(bus.lat_max_o), 5);
    chk("t2_lat_held", 32'(bus.lat_o), 5);

    // 3. Back-pressure: ready low for four cycles in REQ
    push_entry(16'd16, 16'd20, 5'h03, 32'h1234_5678);
    bus.req_ready_i = 1'b0;
    cyc();
    bus.push_i = 1'b0;
    settle();
    chk("t3_count", 32'(bus.count_o), 17);
    cyc();
    cyc();
    cyc();
    settle();
    for (int k = 0; k < 4; k++) begin
      chk("t3_hold_count", 32'(bus.count_o), 20 + k);
      chk("t3_hold_valid", 32'(bus.req_valid_o), 1);
      chk("t3_hold_pop", 32'(bus.pop_o), 0);
      chk("t3_hold_ram", 32'(bus.req_ram_o), 32'h03);
      chk("t3_hold_addr", bus.req_addr_o, 32'h1234_5678);
      cyc();
      settle();
    end
    chk("t3_ready_low_pop", 32'(bus.pop_o), 0);
    bus.req_ready_i = 1'b1;
    settle();
    chk("t3_pop", 32'(bus.pop_o), 1);
    chk("t3_lat", 32'(bus.lat_o), 8);
    cyc();
    settle();
    chk("t3_after_pop", 32'(bus.pop_o), 0);
    chk("t3_after_valid", 32'(bus.req_valid_o), 0);
    chk("t3_after_occ", 32'(bus.occ_o), 0);
    chk("t3_lat_max", 32'(bus.lat_max_o), 8);

    // 4. Release time across the timebase wrap
    for (int i = 0; i < 70000 && bus.count_o != 16'hfffc; i++) cyc();
    settle();
    chk("t4_count_at_push", 32'(bus.count_o), 32'hfffc);
    push_entry(16'hfffc, 16'h0002, 5'h1f, 32'hcafe_0001);
    cyc();
    bus.push_i = 1'b0;
    settle();
    chk("t4_valid_fffd", 32'(bus.req_valid_o), 0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      settle();
      chk("t4_wrap_count", 32'(bus.count_o), 32'(16'(16'hfffe + k)));
      chk("t4_not_due", 32'(bus.req_valid_o), 0);
    end
    cyc();
    settle();
    chk("t4_due_count", 32'(bus.count_o), 2);
    chk("t4_due_valid", 32'(bus.req_valid_o), 1);
    chk("t4_pop", 32'(bus.pop_o), 1);
    chk("t4_lat", 32'(bus.lat_o), 6);
    chk("t4_addr", bus.req_addr_o, 32'hcafe_0001);
    cyc();
    settle();
    chk("t4_after_occ", 32'(bus.occ_o), 0);
    chk("t4_lat_max_kept", 32'(bus.lat_max_o), 8);

    // 5. Stall for three cycles while a ready request is pending
    push_entry(16'd3, 16'd6, 5'h07, 32'h0000_5555);
    cyc();
    bus.push_i = 1'b0;
    cyc();
    settle();
    chk("t5_pre_valid", 32'(bus.req_valid_o), 0);
    cyc();
    bus.stall_i = 1'b1;
    settle();
    chk("t5_stall_valid", 32'(bus.req_valid_o), 1);
    chk("t5_stall_pop_a", 32'(bus.pop_o), 0);
    chk("t5_stall_lat_valid", 32'(bus.lat_valid_o), 0);
    chk("t5_stall_count_a", 32'(bus.count_o), 6);
    cyc();
    bus.push_i = 1'b1;
    settle();
    chk("t5_stall_count_b", 32'(bus.count_o), 6);
    chk("t5_stall_pop_b", 32'(bus.pop_o), 0);
    cyc();
    bus.push_i = 1'b0;
    settle();
    chk("t5_stall_count_c", 32'(bus.count_o), 6);
    chk("t5_stall_occ", 32'(bus.occ_o), 1);
    chk("t5_stall_pop_c", 32'(bus.pop_o), 0);
    cyc();
    bus.stall_i = 1'b0;
    settle();
    chk("t5_release_count", 32'(bus.count_o), 6);
    chk("t5_release_pop", 32'(bus.pop_o), 1);
    chk("t5_release_lat", 32'(bus.lat_o), 3);
    cyc();
    settle();
    chk("t5_after_count", 32'(bus.count_o), 7);
    chk("t5_after_occ", 32'(bus.occ_o), 0);
    chk("t5_after_state", 32'(bus.state), 32'(IDLE));

    // 6. Fill to the full mark, overflow push, then drain
    bus.req_ready_i = 1'b0;
    push_entry(16'd0, 16'd0, 5'h00, 32'h0000_0000);
    for (int k = 1; k <= 32; k++) begin
      cyc();
      settle();
      chk("t6_fill_occ", 32'(bus.occ_o), (k < 31) ? k : 31);
    end
    chk("t6_fill_count", 32'(bus.count_o), 39);
    bus.push_i      = 1'b0;
    bus.req_ready_i = 1'b1;
    settle();
    npops = 0;
    for (int d = 0; d < 62; d++) begin
      chk("t6_drain_pop", 32'(bus.pop_o), (d % 2 == 0) ? 1 : 0);
      chk("t6_drain_occ", 32'(bus.occ_o), 31 - (d + 1) / 2);
      if (d == 0) chk("t6_first_lat", 32'(bus.lat_o), 39);
      npops += int'(bus.pop_o);
      cyc();
      settle();
    end
    chk("t6_pop_total", npops, 31);
    chk("t6_end_occ", 32'(bus.occ_o), 0);
    chk("t6_end_state", 32'(bus.state), 32'(IDLE));
    chk("t6_end_pop", 32'(bus.pop_o), 0);
    chk("t6_lat_max", 32'(bus.lat_max_o), 99);

    // 7. Reset while a request is pending
    bus.req_ready_i = 1'b0;
    push_entry(16'h0050, 16'd0, 5'h11, 32'h0bad_f00d);
    cyc();
    bus.push_i = 1'b0;
    cyc();
    settle();
    chk("t7_pending_valid", 32'(bus.req_valid_o), 1);
    chk("t7_pending_occ", 32'(bus.occ_o), 1);
    reset           = 1'b1;
    bus.req_ready_i = 1'b1;
    settle();
    chk("t7_reset_no_pop", 32'(bus.pop_o), 0);
    cyc();
    reset           = 1'b0;
    bus.req_ready_i = 1'b0;
    settle();
    chk("t7_count", 32'(bus.count_o), 0);
    chk("t7_valid", 32'(bus.req_valid_o), 0);
    chk("t7_occ", 32'(bus.occ_o), 0);
    chk("t7_state", 32'(bus.state), 32'(IDLE));
    chk("t7_lat_max", 32'(bus.lat_max_o), 0);
    chk("t7_lat", 32'(bus.lat_o), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
